// File: rtl/memio_pkg.sv
// Shared types and constants for the mem_io_bridge CPU-to-RAM/UART bridge.
package memio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAM_ISSUE = 2'd1,
    RAM_WAIT  = 2'd2,
    ACK       = 2'd3
  } state_t;

  localparam logic [15:0] DEF_UART_TX_ADDR   = 16'h0FF0;
  localparam logic [15:0] DEF_UART_STAT_ADDR = 16'h0FF2;

  // Big-endian lane: the lowest byte offset lands in the most significant lane.
  function automatic int unsigned lane_idx(input int unsigned nb, input int unsigned offset);
    return nb - 1 - offset;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU-side request/ack bus of mem_io_bridge; err exists only when MEMIO_ALIGN_CHK_EN is defined.
interface mem_io_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic              be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
`ifdef MEMIO_ALIGN_CHK_EN
  logic              err;

  modport master (output req, we, be, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, be, addr, wdata, output rdata, ack, err);
`else
  modport master (output req, we, be, addr, wdata, input rdata, ack);
  modport slave  (input req, we, be, addr, wdata, output rdata, ack);
`endif
endinterface

// File: rtl/memio_txq.sv
// Synchronous FIFO for UART TX bytes; push while full is legal only together with a pop.
module memio_txq #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage is not reset; only pointers and count are, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-to-RAM/UART bridge: req/ack FSM, big-endian lane steering, TX queue MMIO.
// Define MEMIO_ALIGN_CHK_EN to add cpu err reporting for misaligned word accesses.
module mem_io_bridge
  import memio_pkg::*;
#(
  parameter int              DATA_W         = 16,
  parameter int              ADDR_W         = 16,
  parameter int              RAM_LAT        = 1,
  parameter int              TXQ_DEPTH      = 8,
  parameter logic [ADDR_W-1:0] UART_TX_ADDR   = ADDR_W'(DEF_UART_TX_ADDR),
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_W'(DEF_UART_STAT_ADDR)
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_io_bridge_if.slave       cpu,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [DATA_W/8-1:0]  ram_be,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic [7:0]           uart_tx_byte,
  output logic                 uart_tx_valid,
  input  logic                 uart_tx_ready
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int CW    = $clog2(TXQ_DEPTH) + 1;
  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rd_shift;
  logic              we_q, be_q, mis_q, mis_now;
  logic [LAT_W-1:0]  wait_cnt;
  logic [LSB-1:0]    lane;
  logic              is_tx, is_stat, tx_write, tx_pop, tx_push, stall, accept, issue, ack;
  logic              q_full, q_empty;
  logic [CW-1:0]     q_count;
  logic [7:0]        q_head;

  assign is_tx    = (cpu.addr == UART_TX_ADDR);
  assign is_stat  = (cpu.addr == UART_STAT_ADDR);
  assign tx_write = cpu.req && cpu.we && is_tx;
  assign tx_pop   = !q_empty && uart_tx_ready;
  // A full queue still takes the write when a byte leaves in the same cycle.
  assign stall    = tx_write && q_full && !tx_pop;
  assign accept   = (state == IDLE) && cpu.req && !stall;
  assign tx_push  = accept && tx_write;

`ifdef MEMIO_ALIGN_CHK_EN
  assign mis_now = !cpu.be && (cpu.addr[LSB-1:0] != '0);
  assign cpu.err = ack && mis_q;
`else
  assign mis_now = 1'b0;
`endif

  memio_txq #(.DEPTH(TXQ_DEPTH), .W(8)) u_txq (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (cpu.wdata[7:0]),
    .pop       (tx_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    ram_en    = 1'b0;
    unique case (state)
      IDLE:      if (accept) state_nxt = (is_tx || is_stat) ? ACK : RAM_ISSUE;
      RAM_ISSUE: begin
        ram_en    = !(mis_q && we_q);
        state_nxt = we_q ? ACK : RAM_WAIT;
      end
      RAM_WAIT:  if (wait_cnt == '0) state_nxt = ACK;
      ACK: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  assign lane     = LSB'(lane_idx(NB, 32'(addr_q[LSB-1:0])));
  assign rd_shift = ram_rdata >> {lane, 3'b000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= 1'b0;
      mis_q    <= 1'b0;
      wait_cnt <= '0;
    end else if (accept) begin
      addr_q   <= cpu.addr;
      wdata_q  <= cpu.wdata;
      we_q     <= cpu.we;
      be_q     <= cpu.be;
      mis_q    <= mis_now;
      wait_cnt <= LAT_W'(RAM_LAT - 1);
      if (is_stat)    rdata_q <= DATA_W'({q_full, q_empty, q_count});
      else if (is_tx) rdata_q <= '0;
    end else if (state == RAM_WAIT) begin
      if (wait_cnt == '0) begin
        if (mis_q)     rdata_q <= '0;
        else if (be_q) rdata_q <= DATA_W'(rd_shift[7:0]);
        else           rdata_q <= ram_rdata;
      end else begin
        wait_cnt <= wait_cnt - LAT_W'(1);
      end
    end
  end

  // RAM address/data/lane fields are held at zero outside the issue cycle.
  assign issue     = (state == RAM_ISSUE);
  assign ram_we    = issue && we_q;
  assign ram_addr  = issue ? (addr_q >> LSB) : '0;
  assign ram_be    = !issue ? '0 : (be_q ? (NB'(1) << lane) : '1);
  assign ram_wdata = !issue ? '0 :
                     (be_q ? (DATA_W'(wdata_q[7:0]) << {lane, 3'b000}) : wdata_q);

  assign cpu.ack       = ack;
  assign cpu.rdata     = rdata_q;
  assign uart_tx_valid = !q_empty;
  assign uart_tx_byte  = q_empty ? 8'h00 : q_head;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: RAM_LAT=1 and RAM_LAT=3 instances with behavioural RAMs.
module tb_mem_io_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_io_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  mem_io_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();

  logic        ram_en1, ram_we1, tx_valid1, tx_ready1;
  logic [1:0]  ram_be1;
  logic [15:0] ram_addr1, ram_wdata1, ram_rdata1;
  logic [7:0]  tx_byte1;
  logic        ram_en3, ram_we3, tx_valid3, tx_ready3;
  logic [1:0]  ram_be3;
  logic [15:0] ram_addr3, ram_wdata3, ram_rdata3;
  logic [7:0]  tx_byte3;

  mem_io_bridge #(.DATA_W(16), .ADDR_W(16), .RAM_LAT(1), .TXQ_DEPTH(8),
                  .UART_TX_ADDR(16'h0FF0), .UART_STAT_ADDR(16'h0FF2)) dut1 (
    .clk(clk), .reset(reset), .cpu(bus1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_be(ram_be1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1),
    .uart_tx_byte(tx_byte1), .uart_tx_valid(tx_valid1), .uart_tx_ready(tx_ready1));

  mem_io_bridge #(.DATA_W(16), .ADDR_W(16), .RAM_LAT(3), .TXQ_DEPTH(8),
                  .UART_TX_ADDR(16'h0FF0), .UART_STAT_ADDR(16'h0FF2)) dut3 (
    .clk(clk), .reset(reset), .cpu(bus3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_be(ram_be3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3),
    .uart_tx_byte(tx_byte3), .uart_tx_valid(tx_valid3), .uart_tx_ready(tx_ready3));

  // Behavioural RAMs; a non-read cycle pushes a poison word so mistimed captures show up.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [3];
  int          en_cnt1 = 0, en_cnt3 = 0;
  logic [15:0] cap_addr1, cap_wdata1;
  logic [1:0]  cap_be1;
  logic [7:0]  got [$];

  always @(posedge clk) begin
    if (ram_en1 && ram_we1) begin
      if (ram_be1[0]) mem1[ram_addr1[7:0]][7:0]  <= ram_wdata1[7:0];
      if (ram_be1[1]) mem1[ram_addr1[7:0]][15:8] <= ram_wdata1[15:8];
    end
    pipe1 <= (ram_en1 && !ram_we1) ? mem1[ram_addr1[7:0]] : 16'hDEAD;
    if (ram_en1) begin
      en_cnt1    <= en_cnt1 + 1;
      cap_addr1  <= ram_addr1;
      cap_be1    <= ram_be1;
      cap_wdata1 <= ram_wdata1;
    end
    if (tx_valid1 && tx_ready1) got.push_back(tx_byte1);
  end
  assign ram_rdata1 = pipe1;

  always @(posedge clk) begin
    if (ram_en3 && ram_we3) begin
      if (ram_be3[0]) mem3[ram_addr3[7:0]][7:0]  <= ram_wdata3[7:0];
      if (ram_be3[1]) mem3[ram_addr3[7:0]][15:8] <= ram_wdata3[15:8];
    end
    pipe3[0] <= (ram_en3 && !ram_we3) ? mem3[ram_addr3[7:0]] : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (ram_en3) en_cnt3 <= en_cnt3 + 1;
  end
  assign ram_rdata3 = pipe3[2];

  int n_checks = 0;
  int n_errors = 0;
`ifdef MEMIO_ALIGN_CHK_EN
  logic last_err;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, we, be, input logic [15:0] addr, wdata);
    if (sel) begin
      bus3.req = req; bus3.we = we; bus3.be = be; bus3.addr = addr; bus3.wdata = wdata;
    end else begin
      bus1.req = req; bus1.we = we; bus1.be = be; bus1.addr = addr; bus1.wdata = wdata;
    end
  endtask

  // Starts in an IDLE cycle; lat counts cycles from the sampling cycle to the ack cycle.
  task automatic do_access(input bit sel, input logic we, be, input logic [15:0] addr, wdata,
                           output int lat, output logic [15:0] rdata, output int en_delta);
    int   en0;
    logic ack;
    @(negedge clk);
    en0   = sel ? en_cnt3 : en_cnt1;
    lat   = -1;
    rdata = '0;
    drive(sel, 1'b1, we, be, addr, wdata);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      ack = sel ? bus3.ack : bus1.ack;
      if (ack) begin
        lat   = n;
        rdata = sel ? bus3.rdata : bus1.rdata;
`ifdef MEMIO_ALIGN_CHK_EN
        last_err = sel ? bus3.err : bus1.err;
`endif
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    en_delta = (sel ? en_cnt3 : en_cnt1) - en0;
  endtask

  typedef struct {
    string       name;
    logic        we, be;
    logic [15:0] addr, wdata;
    int          lat, en;
    logic [15:0] rdata, raddr;
    logic [1:0]  rbe;
    logic [15:0] rwdata;
  } vec_t;

  function automatic vec_t mk(input string name, input logic we, be, input logic [15:0] addr, wdata,
                              input int lat, en, input logic [15:0] rdata, raddr,
                              input logic [1:0] rbe, input logic [15:0] rwdata);
    vec_t v;
    v.name = name; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.en = en; v.rdata = rdata; v.raddr = raddr; v.rbe = rbe; v.rwdata = rwdata;
    return v;
  endfunction

  initial begin
    vec_t        vecs [$];
    int          lat, en_d, acks;
    logic [15:0] rd;

    reset = 1'b1;
    tx_ready1 = 1'b0;
    tx_ready3 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    check("rst ack",    32'(bus1.ack),   32'h0);
    check("rst ram_en", 32'(ram_en1),    32'h0);
    check("rst ram_be", 32'(ram_be1),    32'h0);
    check("rst rdata",  32'(bus1.rdata), 32'h0);
    check("rst txv",    32'(tx_valid1),  32'h0);
    reset = 1'b0;

    //        name        we    be    addr      wdata     lat en rdata     raddr     be     wdata
    vecs.push_back(mk("ww_0100", 1'b1, 1'b0, 16'h0100, 16'h1234, 2, 1, 16'h0000, 16'h0080, 2'b11, 16'h1234));
    vecs.push_back(mk("wr_0100", 1'b0, 1'b0, 16'h0100, 16'h0000, 3, 1, 16'h1234, 16'h0080, 2'b00, 16'h0000));
    vecs.push_back(mk("bw_0101", 1'b1, 1'b1, 16'h0101, 16'h55AB, 2, 1, 16'h0000, 16'h0080, 2'b01, 16'h00AB));
    vecs.push_back(mk("bw_0100", 1'b1, 1'b1, 16'h0100, 16'h77CD, 2, 1, 16'h0000, 16'h0080, 2'b10, 16'hCD00));
    vecs.push_back(mk("br_0100", 1'b0, 1'b1, 16'h0100, 16'h0000, 3, 1, 16'h00CD, 16'h0080, 2'b00, 16'h0000));
    vecs.push_back(mk("br_0101", 1'b0, 1'b1, 16'h0101, 16'h0000, 3, 1, 16'h00AB, 16'h0080, 2'b00, 16'h0000));
    vecs.push_back(mk("wr_mix",  1'b0, 1'b0, 16'h0100, 16'h0000, 3, 1, 16'hCDAB, 16'h0080, 2'b00, 16'h0000));
`ifdef MEMIO_ALIGN_CHK_EN
    vecs.push_back(mk("wr_odd",  1'b0, 1'b0, 16'h0101, 16'h0000, 3, 1, 16'h0000, 16'h0080, 2'b00, 16'h0000));
`else
    vecs.push_back(mk("wr_odd",  1'b0, 1'b0, 16'h0101, 16'h0000, 3, 1, 16'hCDAB, 16'h0080, 2'b00, 16'h0000));
`endif
    vecs.push_back(mk("ww_01fe", 1'b1, 1'b0, 16'h01FE, 16'hBEEF, 2, 1, 16'h0000, 16'h00FF, 2'b11, 16'hBEEF));
    vecs.push_back(mk("wr_01fe", 1'b0, 1'b0, 16'h01FE, 16'h0000, 3, 1, 16'hBEEF, 16'h00FF, 2'b00, 16'h0000));
    vecs.push_back(mk("st_empt", 1'b0, 1'b0, 16'h0FF2, 16'h0000, 1, 0, 16'h0010, 16'h0000, 2'b00, 16'h0000));
    vecs.push_back(mk("tx_read", 1'b0, 1'b0, 16'h0FF0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000));
    vecs.push_back(mk("st_wr",   1'b1, 1'b0, 16'h0FF2, 16'hFFFF, 1, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000));

    foreach (vecs[i]) begin
      do_access(1'b0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, lat, rd, en_d);
      check({vecs[i].name, " lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, " ram_en"}, 32'(en_d), 32'(vecs[i].en));
      if (!vecs[i].we) check({vecs[i].name, " rdata"}, 32'(rd), 32'(vecs[i].rdata));
      if (vecs[i].en != 0) check({vecs[i].name, " ram_addr"}, 32'(cap_addr1), 32'(vecs[i].raddr));
      if (vecs[i].we && vecs[i].en != 0) begin
        check({vecs[i].name, " ram_be"}, 32'(cap_be1), 32'(vecs[i].rbe));
        check({vecs[i].name, " ram_wdata"}, 32'(cap_wdata1), 32'(vecs[i].rwdata));
      end
    end

    // Fill the TX queue with the UART stalled, then overflow it by one.
    for (int i = 0; i < 8; i++) begin
      do_access(1'b0, 1'b1, 1'b0, 16'h0FF0, 16'h0010 + 16'(i), lat, rd, en_d);
      check($sformatf("txw%0d lat", i), 32'(lat), 32'd1);
    end
    do_access(1'b0, 1'b0, 1'b0, 16'h0FF2, 16'h0000, lat, rd, en_d);
    check("st_full rdata", 32'(rd), 32'h0028);
    check("tx ram_en", 32'(en_cnt1), 32'(en_cnt1 - en_d));
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0FF0, 16'h0018);
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(bus1.ack);
    end
    check("stall acks", 32'(acks), 32'd0);
    tx_ready1 = 1'b1;
    @(negedge clk);
    tx_ready1 = 1'b0;
    check("stall release ack", 32'(bus1.ack), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("first pop count", 32'(got.size()), 32'd1);
    do_access(1'b0, 1'b0, 1'b0, 16'h0FF2, 16'h0000, lat, rd, en_d);
    check("st_refill rdata", 32'(rd), 32'h0028);
    tx_ready1 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!tx_valid1) break;
    end
    tx_ready1 = 1'b0;
    check("drain count", 32'(got.size()), 32'd9);
    if (got.size() == 9)
      for (int i = 0; i < 9; i++) check($sformatf("drain byte%0d", i), 32'(got[i]), 32'h10 + 32'(i));
    do_access(1'b0, 1'b0, 1'b0, 16'h0FF2, 16'h0000, lat, rd, en_d);
    check("st_drained rdata", 32'(rd), 32'h0010);

    // RAM_LAT=3 instance.
    do_access(1'b1, 1'b1, 1'b0, 16'h0100, 16'h4321, lat, rd, en_d);
    check("l3 write lat", 32'(lat), 32'd2);
    do_access(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, lat, rd, en_d);
    check("l3 read lat", 32'(lat), 32'd5);
    check("l3 read rdata", 32'(rd), 32'h4321);
    check("l3 read en cycles", 32'(en_d), 32'd1);
    do_access(1'b1, 1'b0, 1'b0, 16'h0FF2, 16'h0000, lat, rd, en_d);
    check("l3 mmio lat", 32'(lat), 32'd1);
    check("l3 mmio en", 32'(en_d), 32'd0);
    do_access(1'b1, 1'b1, 1'b0, 16'h0FF0, 16'h0055, lat, rd, en_d);
    check("l3 tx en", 32'(en_d), 32'd0);

    // Reset while dut1 sits in RAM_WAIT with a byte queued.
    do_access(1'b0, 1'b1, 1'b0, 16'h0FF0, 16'h0077, lat, rd, en_d);
    check("pre-rst txv", 32'(tx_valid1), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst ack", 32'(bus1.ack), 32'd0);
    check("midrst ram_en", 32'(ram_en1), 32'd0);
    check("midrst txv", 32'(tx_valid1), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("midrst no ack", 32'(bus1.ack), 32'd0);
    reset = 1'b0;
    do_access(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, lat, rd, en_d);
    check("postrst lat", 32'(lat), 32'd3);
    check("postrst rdata", 32'(rd), 32'hCDAB);
    check("postrst txv", 32'(tx_valid1), 32'd0);

`ifdef MEMIO_ALIGN_CHK_EN
    do_access(1'b0, 1'b1, 1'b0, 16'h0101, 16'h9999, lat, rd, en_d);
    check("mis ww lat", 32'(lat), 32'd2);
    check("mis ww err", 32'(last_err), 32'd1);
    check("mis ww en", 32'(en_d), 32'd0);
    do_access(1'b0, 1'b1, 1'b1, 16'h0101, 16'h0011, lat, rd, en_d);
    check("bw err", 32'(last_err), 32'd0);
    check("bw en", 32'(en_d), 32'd1);
    do_access(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, lat, rd, en_d);
    check("mis ww no write", 32'(rd), 32'hCD11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sequential, parametrised CPU-to-memory/IO bridge with a registered req/ack handshake toward the CPU and a fixed-latency synchronous RAM port.
- Converts byte addresses to word addresses and steers byte lanes big-endian: the lower address maps to the upper lane.
- Decodes a memory-mapped UART TX data register and a status register. TX data goes through a buffered queue with a valid/ready drain toward the UART transmitter.
- Sits between the CPU core and on-chip RAM and UART.

Parameters:
- DATA_W, 16: CPU/RAM data width; a multiple of 8, at least 16.
- ADDR_W, 16: CPU byte-address width.
- RAM_LAT, 1: RAM read latency in cycles, from ram_en to valid ram_rdata; at least 1.
- TXQ_DEPTH, 8: UART TX queue depth; a power of 2, at least 2.
- UART_TX_ADDR, 16'h0FF0: byte address of the TX data register.
- UART_STAT_ADDR, 16'h0FF2: byte address of the TX status register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_be  in  1  1 = byte access, 0 = full word.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data; a byte write uses bits [7:0].
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_be  out  DATA_W/8  lane enables; bit NB-1 is the upper byte.
- ram_addr  out  ADDR_W  word address = cpu_addr >> log2(NB), zero-filled at the top.
- ram_wdata  out  DATA_W  lane-steered write data.
- ram_rdata  in  DATA_W  RAM read data.
- uart_tx_byte  out  8  head of the TX queue.
- uart_tx_valid  out  1  TX queue not empty.
- uart_tx_ready  in  1  the UART accepts a byte when valid && ready.

Behaviour:
- Definitions: NB = DATA_W/8, LSB = log2(NB), lane = NB-1-cpu_addr[LSB-1:0].
- Reset: all outputs 0; FSM in IDLE; TX queue empty.
- Reset mid-access: the in-flight RAM access is abandoned, no ack is issued, and queue contents are lost.
- FSM states: IDLE, RAM_ISSUE, RAM_WAIT, ACK.
- IDLE, cpu_req=1:
  - cpu_req, addr, wdata, we and be are registered.
  - MMIO address: go to ACK next cycle. Exception: a TX write with the queue full stays in IDLE, re-sampling each cycle, with no ack until space frees (stall).
  - Any other address: go to RAM_ISSUE.
- RAM_ISSUE: ram_en=1 for exactly one cycle, with ram_addr, ram_we, ram_be and ram_wdata driven.
  - Write: go to ACK.
  - Read: go to RAM_WAIT, counting RAM_LAT cycles.
- RAM_WAIT: on count expiry, register ram_rdata and go to ACK.
- ACK: cpu_ack=1 for one cycle, then IDLE. cpu_req is re-sampled only from IDLE, so the minimum request spacing is 2 cycles.
- Ack latency, counted from the IDLE cycle where the request is sampled:
  - MMIO: 1 cycle.
  - RAM write: 2 cycles.
  - RAM read: RAM_LAT+2 cycles.
- Word write: ram_be all ones, ram_wdata = cpu_wdata.
- Byte write: ram_be is one-hot at lane; cpu_wdata[7:0] is placed in that lane and all other lanes are 0.
- Word read: cpu_rdata = ram_rdata.
- Byte read: cpu_rdata = zero-extended lane byte.
- Word access: the low LSB address bits are ignored.
- MMIO accesses never assert ram_en.
- TX data register:
  - Write pushes cpu_wdata[7:0] into the queue.
  - Read returns 0.
- Status register read: {zero-fill, full, empty, count}. count is log2(TXQ_DEPTH)+1 bits and sits at [log2(TXQ_DEPTH):0].
- Queue pop: when uart_tx_valid && uart_tx_ready.
- Simultaneous push and pop: count unchanged, and allowed when full.
- Full-queue stall: the stalled write completes in the cycle after the pop.
- Pointers wrap modulo TXQ_DEPTH.
- Status read timing: the value is sampled in the IDLE cycle.

Optional Feature:
- Macro: MEMIO_ALIGN_CHK_EN.
- Defined:
  - Adds output cpu_err (1 bit, reset 0), pulsed with cpu_ack.
  - Set for a word access with cpu_addr[LSB-1:0] != 0.
  - A misaligned write suppresses ram_en; a misaligned read returns 0.
- Undefined:
  - No cpu_err port.
  - Low address bits are silently ignored.

Decomposition:
- Package memio_pkg holds:
  - the FSM state enum;
  - default MMIO address constants;
  - a lane-index function.
- Sub-module memio_txq: synchronous FIFO with push, pop, full, empty and count.

Test Plan:
- Word write 16'h1234 to 16'h0100, then word read 16'h0100, RAM_LAT=1:
  - write: ram_addr=16'h0080, ram_be=2'b11, ack 2 cycles after sampling;
  - read: cpu_rdata=16'h1234, ack 3 cycles after sampling.
- Byte write 8'hAB to 16'h0101, then byte write 8'hCD to 16'h0100:
  - first: ram_be=2'b01, ram_wdata=16'h00AB;
  - second: ram_be=2'b10, ram_wdata=16'hCD00;
  - byte read of 16'h0100 returns 16'h00CD.
- uart_tx_ready=0 and 9 writes to 16'h0FF0 with TXQ_DEPTH=8:
  - 8 acks, the 9th stalls;
  - status read = {empty=0, full=1, count=8};
  - raise ready for 1 cycle: the 9th write acks and bytes drain in order.
- RAM_LAT=3 read: ack exactly 5 cycles after sampling; ram_en high exactly 1 cycle; no ram_en on any MMIO access.
- Assert reset during RAM_WAIT: cpu_ack, ram_en and uart_tx_valid go 0 immediately; the next request completes normally.
- With MEMIO_ALIGN_CHK_EN: word write to 16'h0101 gives cpu_err=1 with the ack and no ram_en; byte write to 16'h0101 gives cpu_err=0.
